// File: rtl/irq_capture_pkg.sv
// rtl/irq_capture_pkg.sv - shared constants and slot state type for the IRQ pending capture stage
package irq_capture_pkg;

    localparam int N = 16;
    localparam int CODE_W = 8;
    localparam logic [CODE_W-1:0] EMPTY_CODE = 8'hF0;

    typedef enum logic {
        EMPTY = 1'b0,
        OFFER = 1'b1
    } slot_state_e;

endpackage

// File: rtl/prio_enc16.sv
// rtl/prio_enc16.sv - combinational highest-set-bit encoder, 16 inputs
module prio_enc16 (
    input  logic [15:0] in_vec,
    output logic [3:0]  idx,
    output logic        any
);

    // Ascending scan so the highest set bit is the last one written
    always_comb begin
        idx = 4'd0;
        any = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (in_vec[i]) begin
                idx = 4'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_capture.sv
// rtl/irq_pending_capture.sv - sticky pending capture with mask and one-grant-per-cycle code offer
module irq_pending_capture #(
    parameter int N = irq_capture_pkg::N,
    parameter int CODE_W = irq_capture_pkg::CODE_W,
    parameter logic [CODE_W-1:0] EMPTY_CODE = irq_capture_pkg::EMPTY_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_i,
    input  logic [N-1:0]      mask_i,
    input  logic              clr_all_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [N-1:0]      pending_o,
    output logic              ovf_o
);

    import irq_capture_pkg::*;

    logic [N-1:0]      req_q;
    logic [N-1:0]      rise;
    logic [N-1:0]      pending_q;
    logic              ovf_q;
    logic              acc;
    logic [N-1:0]      acc_vec;
    logic [N-1:0]      elig;
    logic [3:0]        enc_idx;
    logic              enc_any;
    slot_state_e       state_q;
    slot_state_e       state_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;

    // Previous request levels; sampled even in reset so a held level is not seen as an edge
    always_ff @(posedge clk) begin
        req_q <= req_i;
    end

    assign rise = req_i & ~req_q;
    assign acc  = (state_q == OFFER) && ready_i;

    // One-hot of the offered index when the consumer takes it this cycle
    always_comb begin
        acc_vec = '0;
        if (acc) begin
            acc_vec[code_q[3:0]] = 1'b1;
        end
    end

    // Current-cycle edges are excluded so they become eligible one cycle later
    assign elig = pending_q & ~acc_vec & ~mask_i;

    prio_enc16 u_enc (
        .in_vec (elig),
        .idx    (enc_idx),
        .any    (enc_any)
    );

    // Pending and overflow bookkeeping; an edge on a just-accepted bit re-arms it without overflow
    always_ff @(posedge clk) begin
        if (rst || clr_all_i) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~acc_vec) | rise;
            ovf_q     <= ovf_q | (|(rise & pending_q & ~acc_vec));
        end
    end

    // Output slot register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            code_q  <= EMPTY_CODE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Slot reloads only when empty or consumed; an unaccepted offer stays frozen
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (clr_all_i) begin
            state_d = EMPTY;
            code_d  = EMPTY_CODE;
        end else if (state_q == EMPTY || acc) begin
            if (enc_any) begin
                state_d = OFFER;
                code_d  = {{(CODE_W-4){1'b0}}, enc_idx};
            end else begin
                state_d = EMPTY;
                code_d  = EMPTY_CODE;
            end
        end
    end

    assign code_o    = code_q;
    assign valid_o   = (state_q == OFFER);
    assign pending_o = pending_q;
    assign ovf_o     = ovf_q;

endmodule
